// File: rtl/rr_arbiter_param_if.sv
// Request/grant bundle between N bus masters and the arbiter.
// Masters drive request; the arbiter drives the registered grant side.
interface rr_arbiter_param_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   request;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;

  modport master (
    output request,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/rr_arbiter_param.sv
// N-way request/grant arbiter, fixed-priority or round-robin,
// with a bounded hold time for the current owner.
module rr_arbiter_param #(
  parameter int N        = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_arbiter_param_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   grant_q, grant_d;
  logic           gv_q, gv_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] last_q, last_d;
  logic [7:0]     hold_q, hold_d;

  logic [N-1:0]   own_oh;
  logic [N-1:0]   elig;
  logic           others;
  logic           expired;
  logic           keep;
  logic           found;
  logic [IDW-1:0] sel;

  assign own_oh  = gv_q ? (N'(1) << gid_q) : '0;
  assign others  = |(bus.request & ~own_oh);
  assign expired = gv_q && (MAX_HOLD != 0)
                && (hold_q >= 8'(MAX_HOLD));
  assign keep    = gv_q && bus.request[gid_q]
                && (!expired || !others);
  // an expired owner steps aside so the scan lands on someone else
  assign elig    = bus.request & ~(expired ? own_oh : '0);

  always_comb begin : sel_c
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      if (RR_MODE != 0) idx = (int'(last_q) + 1 + i) % N;
      else              idx = i;
      if (!found && elig[IDW'(idx)]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    gv_d    = gv_q;
    gid_d   = gid_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if (keep) begin
      hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    end else if (found) begin
      grant_d = N'(1) << sel;
      gv_d    = 1'b1;
      gid_d   = sel;
      last_d  = sel;
      hold_d  = 8'd1;
    end else begin
      grant_d = '0;
      gv_d    = 1'b0;
      gid_d   = '0;
      hold_d  = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q <= '0;
      gv_q    <= 1'b0;
      gid_q   <= '0;
      last_q  <= IDW'(N - 1);
      hold_q  <= 8'd0;
    end else begin
      grant_q <= grant_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_id    = gid_q;
endmodule
